// File: rtl/video_mem_port.sv
// Single-port video RAM: one-cycle video fetch path plus a handshaked CPU port
// with a 4-entry write buffer drained in idle slots and reads ordered behind writes.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no CPU read outstanding, cpu_ready follows FIFO space
//   ST_RD_WAIT | read accepted, waiting for an idle slot with FIFO empty
module video_mem_port #(
    parameter int          AW       = 13,
    parameter logic [15:0] RAM_BASE = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_en,
    input  logic [15:0] vga_addr,
    output logic [7:0]  vga_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic [2:0]  wfifo_level
);

    localparam int   DEPTH      = 1 << AW;
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_RD_WAIT = 1'b1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] fifo_idx [4];
    logic [7:0]    fifo_data [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    level;

    logic          state;
    logic [AW-1:0] rd_idx;
    logic          rd_oor;

    logic vga_in_range;
    logic cpu_in_range;
    logic rd_busy;
    logic accept;
    logic push;
    logic pop;
    logic rd_accept;
    logic rd_issue;

    assign vga_in_range = (vga_addr[15:AW] == RAM_BASE[15:AW]);
    assign cpu_in_range = (cpu_addr[15:AW] == RAM_BASE[15:AW]);

    assign rd_busy     = (state == ST_RD_WAIT);
    assign cpu_ready   = !rd_busy && (level != 3'd4);
    assign wfifo_level = level;

    assign accept    = cpu_req && cpu_ready;
    // Out-of-range writes are acknowledged but never reach the buffer.
    assign push      = accept && cpu_we && cpu_in_range;
    // Drain is suppressed while reset is asserted so queued writes never land.
    assign pop       = reset && !vid_en && (level != 3'd0);
    assign rd_accept = accept && !cpu_we;
    // Out-of-range reads bypass arbitration entirely.
    assign rd_issue  = rd_busy && (rd_oor || (!vid_en && (level == 3'd0)));

    // RAM and buffer storage carry no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (pop) begin
            mem[fifo_idx[rd_ptr]] <= fifo_data[rd_ptr];
        end
        if (push) begin
            fifo_idx[wr_ptr]  <= cpu_addr[AW-1:0];
            fifo_data[wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_data <= 8'h00;
        end else if (vid_en) begin
            vga_data <= vga_in_range ? mem[vga_addr[AW-1:0]] : 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            level  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                level <= level + 3'd1;
            end else if (pop && !push) begin
                level <= level - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rd_idx     <= '0;
            rd_oor     <= 1'b0;
            cpu_rdata  <= 8'h00;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_accept) begin
                        state  <= ST_RD_WAIT;
                        rd_idx <= cpu_addr[AW-1:0];
                        rd_oor <= !cpu_in_range;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_issue) begin
                        state      <= ST_IDLE;
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= rd_oor ? 8'hFF : mem[rd_idx];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_mem_port.sv
// Randomized and directed bench for video_mem_port against a queue-based
// behavioural model of the RAM, write buffer and read port.
module tb_video_mem_port;

    logic        clk;
    logic        reset;
    logic        vid_en;
    logic [15:0] vga_addr;
    logic [7:0]  vga_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [2:0]  wfifo_level;

    video_mem_port dut (
        .clk        (clk),
        .reset      (reset),
        .vid_en     (vid_en),
        .vga_addr   (vga_addr),
        .vga_data   (vga_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .wfifo_level(wfifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte array RAM, queue write buffer, one pending read.
    logic [7:0] m_ram [8192];
    bit         m_kn  [8192];
    int         mq_ix [$];
    logic [7:0] mq_d  [$];
    bit         m_busy;
    bit         m_rd_in;
    int         m_rd_ix;
    logic [7:0] m_vga;
    bit         m_vga_k;
    logic [7:0] m_rdata;
    bit         m_rdata_k;
    bit         m_rvalid;
    bit         m_started = 0;

    function automatic bit inr(input logic [15:0] a);
        return (int'(a) / 8192) == (int'(16'h1000) / 8192);
    endfunction

    function automatic int ix(input logic [15:0] a);
        return int'(a) % 8192;
    endfunction

    initial begin
        for (int i = 0; i < 8192; i++) m_kn[i] = 0;
    end

    always @(posedge clk) begin
        bit acc;
        if (!reset) begin
            mq_ix.delete();
            mq_d.delete();
            m_busy    = 0;
            m_vga     = 8'h00;
            m_vga_k   = 1;
            m_rdata   = 8'h00;
            m_rdata_k = 1;
            m_rvalid  = 0;
            m_started = 1;
        end else if (m_started) begin
            acc = cpu_req && !m_busy && (mq_ix.size() < 4);
            if (vid_en) begin
                if (inr(vga_addr)) begin
                    m_vga   = m_ram[ix(vga_addr)];
                    m_vga_k = m_kn[ix(vga_addr)];
                end else begin
                    m_vga   = 8'hFF;
                    m_vga_k = 1;
                end
            end
            m_rvalid = 0;
            if (m_busy && (!m_rd_in || (!vid_en && mq_ix.size() == 0))) begin
                m_rvalid = 1;
                m_busy   = 0;
                if (m_rd_in) begin
                    m_rdata   = m_ram[m_rd_ix];
                    m_rdata_k = m_kn[m_rd_ix];
                end else begin
                    m_rdata   = 8'hFF;
                    m_rdata_k = 1;
                end
            end
            if (!vid_en && mq_ix.size() > 0) begin
                m_ram[mq_ix[0]] = mq_d[0];
                m_kn[mq_ix[0]]  = 1;
                void'(mq_ix.pop_front());
                void'(mq_d.pop_front());
            end
            if (acc) begin
                if (cpu_we) begin
                    if (inr(cpu_addr)) begin
                        mq_ix.push_back(ix(cpu_addr));
                        mq_d.push_back(cpu_wdata);
                    end
                end else begin
                    m_busy  = 1;
                    m_rd_in = inr(cpu_addr);
                    m_rd_ix = ix(cpu_addr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rvalid));
            chk("wfifo_level", 32'(wfifo_level), 32'(mq_ix.size()));
            chk("cpu_ready", 32'(cpu_ready), 32'(!m_busy && mq_ix.size() != 4));
            if (m_vga_k) chk("vga_data", 32'(vga_data), 32'(m_vga));
            if (m_rdata_k) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        end
    end

    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d);
        int  n;
        logic acc;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        n = 0;
        do begin
            acc = cpu_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        cpu_req = 1'b0;
        chk("cpu_op_accept", 32'(acc), 32'd1);
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [15:0] r;
        r = 16'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) return 16'h1000 + r;
        case ($urandom_range(0, 2))
            0:       return 16'h2000 + r;
            1:       return 16'h4000 + r;
            default: return 16'hF000 + r;
        endcase
    endfunction

    initial begin
        int acc_cnt;
        int hit;
        logic acc;

        reset     = 1'b0;
        vid_en    = 1'b0;
        vga_addr  = 16'h1000;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h1000;
        cpu_wdata = 8'h00;

        // Reset held two cycles with a request pending.
        repeat (2) @(negedge clk);
        chk("rst_vga_data", 32'(vga_data), 32'h00);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_level", 32'(wfifo_level), 32'h0);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h1);

        // Give every byte of the working window a known value.
        for (int i = 0; i < 64; i++) cpu_op(1'b1, 16'h1000 + 16'(i), 8'(i * 7 + 3));
        repeat (2) @(negedge clk);

        // Video read of a freshly written byte, then an out-of-range fetch.
        cpu_op(1'b1, 16'h1005, 8'hA5);
        @(negedge clk);
        vid_en   = 1'b1;
        vga_addr = 16'h1005;
        @(negedge clk);
        chk("vid_read_a5", 32'(vga_data), 32'hA5);
        vga_addr = 16'h3000;
        @(negedge clk);
        chk("vid_read_oor", 32'(vga_data), 32'hFF);

        // Fill the buffer under video ownership, then drain.
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 16'h1030 + 16'(i);
            cpu_wdata = 8'hC0 + 8'(i);
            acc = cpu_ready;
            if (acc) acc_cnt++;
            @(negedge clk);
        end
        chk("full_accepted", 32'(acc_cnt), 32'd4);
        chk("full_level", 32'(wfifo_level), 32'd4);
        chk("full_ready", 32'(cpu_ready), 32'd0);
        cpu_req = 1'b0;
        vid_en  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            chk("drain_level", 32'(wfifo_level), 32'(k));
        end
        cpu_req = 1'b1;
        acc = cpu_ready;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("fifth_write_accepted", 32'(acc), 32'd1);
        repeat (2) @(negedge clk);

        // Read queued behind a write while video holds the RAM.
        vid_en = 1'b1;
        cpu_op(1'b1, 16'h1010, 8'h5A);
        cpu_op(1'b0, 16'h1010, 8'h00);
        repeat (3) @(negedge clk);
        vid_en = 1'b0;
        hit = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (cpu_rvalid && hit == 0) begin
                hit = k;
                chk("order_rdata", 32'(cpu_rdata), 32'h5A);
            end
        end
        chk("order_latency", 32'(hit), 32'd2);

        // Out-of-range read completes immediately even with video active.
        vid_en = 1'b1;
        cpu_op(1'b0, 16'h4000, 8'h00);
        @(negedge clk);
        chk("oor_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("oor_rdata", 32'(cpu_rdata), 32'hFF);
        @(negedge clk);
        chk("oor_rvalid_drop", 32'(cpu_rvalid), 32'd0);

        // Reset with writes queued and a read pending.
        cpu_op(1'b1, 16'h1020, 8'h11);
        cpu_op(1'b1, 16'h1021, 8'h22);
        cpu_op(1'b1, 16'h1022, 8'h33);
        cpu_op(1'b0, 16'h1023, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_level", 32'(wfifo_level), 32'd0);
        chk("midrst_rvalid", 32'(cpu_rvalid), 32'd0);
        vid_en = 1'b0;
        hit = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_rvalid) hit++;
        end
        chk("midrst_no_rvalid", 32'(hit), 32'd0);
        vid_en   = 1'b1;
        vga_addr = 16'h1020;
        @(negedge clk);
        chk("midrst_keep_1020", 32'(vga_data), 32'hE3);
        vga_addr = 16'h1021;
        @(negedge clk);
        chk("midrst_keep_1021", 32'(vga_data), 32'hEA);
        vga_addr = 16'h1022;
        @(negedge clk);
        chk("midrst_keep_1022", 32'(vga_data), 32'hF1);

        // Randomized traffic, checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) != 0);
            vid_en    = ($urandom_range(0, 1) == 1);
            vga_addr  = rnd_addr();
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = ($urandom_range(0, 1) == 1);
            cpu_addr  = rnd_addr();
            cpu_wdata = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        reset   = 1'b1;
        cpu_req = 1'b0;
        vid_en  = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
